uart_rx_cmd: RTL and testbench

//  Serial receiver for BLE command bytes ('g' = 0x67 go, 's' = 0x73 stop) on the Segway RX pin.

---
 rtl/uart_rx_cmd_if.sv | 30 +++
 rtl/uart_rx_cmd.sv | 146 ++++++++++++++
 tb/tb_uart_rx_cmd.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_cmd_if.sv
// Signal bundle between the RX pin / consumer side and the uart_rx_cmd receiver.
// The master drives the serial line and the ack; the slave (receiver) returns byte and status.
interface uart_rx_cmd_if #(
   parameter int DATA_BITS = 8
);
   logic                 RX;
   logic                 clr_rdy;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rdy;
   logic                 frm_err;
   logic                 busy;

   modport master (
      output RX,
      output clr_rdy,
      input  rx_data,
      input  rdy,
      input  frm_err,
      input  busy
   );

   modport slave (
      input  RX,
      input  clr_rdy,
      output rx_data,
      output rdy,
      output frm_err,
      output busy
   );
endinterface

// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver for BLE command bytes: mid-bit sampling, start-glitch reject, framing error.
// Optional `define RX_MAJ_VOTE_EN: 2-of-3 majority sample around each strobe (+1 clk latency).
module uart_rx_cmd #(
   parameter int CLKS_PER_BIT = 2604,
   parameter int DATA_BITS    = 8
) (
   input logic          clk,
   input logic          rst,
   uart_rx_cmd_if.slave bus
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 r_state;
   logic                   r_rx_meta;
   logic                   r_rx_s;
   logic                   r_rx_d;
   logic [CW-1:0]          r_baud;
   logic [BW-1:0]          r_bit_cnt;
   logic [DATA_BITS-1:0]   r_shift;
   logic [DATA_BITS-1:0]   r_rx_data;
   logic                   r_rdy;
   logic                   r_frm_err;

   logic w_fall;
   logic w_strobe;
   logic w_act;
   logic w_sample;

   // Sync flops preset high so the line looks idle straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_d    <= 1'b1;
      end else begin
         r_rx_meta <= bus.RX;
         r_rx_s    <= r_rx_meta;
         r_rx_d    <= r_rx_s;
      end
   end

   assign w_fall   = r_rx_d & ~r_rx_s;
   assign w_strobe = (r_state != IDLE) && (r_baud == CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_baud <= '0;
      end else if ((r_state == IDLE) && w_fall) begin
         r_baud <= HALF_CNT;
      end else if (w_strobe) begin
         r_baud <= FULL_CNT;
      end else if (r_baud != '0) begin
         r_baud <= r_baud - CW'(1);
      end
   end

`ifdef RX_MAJ_VOTE_EN
   logic r_rx_d2;
   logic r_strobe_d;

   // Decision is taken one cycle after the strobe so the strobe+1 sample is available.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_d2    <= 1'b1;
         r_strobe_d <= 1'b0;
      end else begin
         r_rx_d2    <= r_rx_d;
         r_strobe_d <= w_strobe;
      end
   end

   assign w_act    = r_strobe_d;
   assign w_sample = (r_rx_d2 & r_rx_d) | (r_rx_d2 & r_rx_s) | (r_rx_d & r_rx_s);
`else
   assign w_act    = w_strobe;
   assign w_sample = r_rx_s;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_rx_data <= '0;
         r_rdy     <= 1'b0;
         r_frm_err <= 1'b0;
      end else begin
         r_frm_err <= 1'b0;
         if (bus.clr_rdy) begin
            r_rdy <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_rdy   <= 1'b0;
                  r_state <= START;
               end
            end
            START: begin
               if (w_act) begin
                  if (w_sample) begin
                     r_state <= IDLE;
                  end else begin
                     r_bit_cnt <= '0;
                     r_state   <= DATA;
                  end
               end
            end
            DATA: begin
               if (w_act) begin
                  r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
                  if (r_bit_cnt == LAST_BIT) begin
                     r_state <= STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BW'(1);
                  end
               end
            end
            STOP: begin
               // Set of rdy sits after the clr_rdy clear so a same-cycle ack loses.
               if (w_act) begin
                  if (w_sample) begin
                     r_rx_data <= r_shift;
                     r_rdy     <= 1'b1;
                  end else begin
                     r_frm_err <= 1'b1;
                  end
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.rx_data = r_rx_data;
   assign bus.rdy     = r_rdy;
   assign bus.frm_err = r_frm_err;
   assign bus.busy    = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_cmd.sv
// Scoreboard bench for uart_rx_cmd: frames are queued as expected events at issue time,
// a monitor pops them on each rdy rise or frm_err pulse. Honours RX_MAJ_VOTE_EN.
`timescale 1ns/1ps
module tb_uart_rx_cmd;
   localparam int CPB = 16;
   localparam int DB  = 8;
`ifdef RX_MAJ_VOTE_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif
   localparam int LAT_NOM = (2 * (DB + 1) + 1) * CPB / 2 + 3 + MAJ;

   typedef struct {
      bit            ferr;
      logic [DB-1:0] data;
      int            t0;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_rx_cmd_if #(.DATA_BITS(DB)) bus ();

   uart_rx_cmd #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   exp_t          exp_q[$];
   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   int            ack_mode = 0;
   logic [DB-1:0] last_good = '0;
   logic          prev_rdy = 1'b0;
   logic          prev_clr = 1'b0;
   logic          prev_ferr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Consumer: never acks, acks at random while rdy, or holds the ack high permanently.
   initial begin
      bus.clr_rdy = 1'b0;
      forever begin
         @(negedge clk);
         case (ack_mode)
            0:       bus.clr_rdy = 1'b0;
            1:       bus.clr_rdy = bus.rdy && ($urandom_range(0, 3) == 0);
            default: bus.clr_rdy = 1'b1;
         endcase
      end
   end

   // Monitor: pops one expected event per rdy rise or frm_err pulse.
   initial begin
      exp_t e;
      int   lat;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (prev_rdy && prev_clr) check("clr_rdy_clears", int'(bus.rdy), 0);
            if (prev_ferr) check("frm_err_width", int'(bus.frm_err), 0);
            if ((bus.rdy && !prev_rdy) || (bus.frm_err && !prev_ferr)) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_event: rdy=%0b frm_err=%0b rx_data=%0h, none required",
                           bus.rdy, bus.frm_err, bus.rx_data);
               end else begin
                  e = exp_q.pop_front();
                  check("event_kind_frm_err", int'(bus.frm_err), int'(e.ferr));
                  if (e.ferr) begin
                     check("rx_data_kept", int'(bus.rx_data), int'(e.data));
                     check("rdy_low_on_ferr", int'(bus.rdy), 0);
                  end else begin
                     check("rx_data", int'(bus.rx_data), int'(e.data));
                  end
                  lat = cyc - e.t0;
                  checks++;
                  if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
                     errors++;
                     $display("FAIL latency: got %0d cycles required %0d +/-1", lat, LAT_NOM);
                  end
                  $display("event ferr=%0b rx_data=%0h latency=%0d", bus.frm_err, bus.rx_data, lat);
               end
            end
         end
         prev_rdy  = bus.rdy;
         prev_clr  = bus.clr_rdy;
         prev_ferr = bus.frm_err;
      end
   end

   task automatic check_reset_outputs();
      check("reset_rdy", int'(bus.rdy), 0);
      check("reset_frm_err", int'(bus.frm_err), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_rx_data", int'(bus.rx_data), 0);
   endtask

   // Drives one 8N1 frame from a negedge. glitch_bit>=0 flips one clk mid data bit;
   // abort_bit>=0 pulses rst in the middle of that data bit and abandons the frame.
   task automatic send_frame(input logic [DB-1:0] data, input bit stop,
                             input int glitch_bit, input int abort_bit);
      exp_t          e;
      logic [DB+1:0] bits;
      bits = {stop, data, 1'b0};
      if (abort_bit < 0) begin
         e.ferr = !stop;
         e.data = stop ? data : last_good;
         e.t0   = cyc;
         exp_q.push_back(e);
         if (stop) last_good = data;
      end
      for (int b = 0; b < DB + 2; b++) begin
         for (int j = 0; j < CPB; j++) begin
            if (abort_bit >= 0 && b - 1 == abort_bit && j == CPB / 2) begin
               rst    = 1'b1;
               bus.RX = 1'b1;
               repeat (3) @(negedge clk);
               rst       = 1'b0;
               last_good = '0;
               check_reset_outputs();
               repeat (2 * CPB) @(negedge clk);
               return;
            end
            if (glitch_bit >= 0 && b - 1 == glitch_bit && j == CPB / 2)
               bus.RX = ~bits[b];
            else
               bus.RX = bits[b];
            @(negedge clk);
         end
      end
      $display("sent data=%0h stop=%0b glitch=%0d", data, stop, glitch_bit);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      int gl;
      bus.RX = 1'b1;
      rst    = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check_reset_outputs();

      // Single good byte then a directed ack.
      send_frame(8'h67, 1'b1, -1, -1);
      repeat (CPB) @(negedge clk);
      check("rdy_after_g", int'(bus.rdy), 1);
      ack_mode = 2;
      repeat (2) @(negedge clk);
      ack_mode = 0;
      repeat (2) @(negedge clk);
      check("rdy_after_ack", int'(bus.rdy), 0);

      // Short low pulse on RX: start is rejected at the START strobe.
      bus.RX = 1'b0;
      repeat (4) @(negedge clk);
      bus.RX = 1'b1;
      repeat (2) @(negedge clk);
      check("busy_in_start", int'(bus.busy), 1);
      repeat (CPB) @(negedge clk);
      check("busy_after_glitch", int'(bus.busy), 0);
      check("rx_data_after_glitch", int'(bus.rx_data), 8'h67);
      check("rdy_after_glitch", int'(bus.rdy), 0);
      repeat (CPB) @(negedge clk);

      // Framing error, then back-to-back good bytes without ack.
      send_frame(8'hA5, 1'b0, -1, -1);
      bus.RX = 1'b1;
      repeat (CPB) @(negedge clk);
      send_frame(8'h67, 1'b1, -1, -1);
      send_frame(8'h73, 1'b1, -1, -1);
      check("rx_data_b2b", int'(bus.rx_data), 8'h73);
      ack_mode = 2;
      send_frame(8'h67, 1'b1, -1, -1);
      ack_mode = 0;

      // Reset in the middle of data bit 4, then a clean byte.
      send_frame(8'h67, 1'b1, -1, 4);
      send_frame(8'h73, 1'b1, -1, -1);
      repeat (CPB) @(negedge clk);
      check("rx_data_after_abort", int'(bus.rx_data), 8'h73);
      check("rdy_after_abort", int'(bus.rdy), 1);

      if (MAJ != 0) begin
         send_frame(8'h67, 1'b1, 2, -1);
         repeat (CPB) @(negedge clk);
         check("rx_data_glitch_bit2", int'(bus.rx_data), 8'h67);
      end

      for (int n = 0; n < 40; n++) begin
         ack_mode = $urandom_range(0, 2);
         gl = (MAJ != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, DB - 1)) : -1;
         if ($urandom_range(0, 4) != 0) begin
            send_frame(8'($urandom), 1'b1, gl, -1);
            gap = $urandom_range(0, 2);
         end else begin
            send_frame(8'($urandom), 1'b0, gl, -1);
            bus.RX = 1'b1;
            gap = $urandom_range(1, 2);
         end
         repeat (gap * CPB) @(negedge clk);
      end
      ack_mode = 0;

      for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
      repeat (4 * CPB) @(negedge clk);
      while (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event: ferr=%0b data=%0h never reported", e.ferr, e.data);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
